aes_decipher_round_par: RTL and testbench

Parametrised, sequential AES inverse-cipher engine covering 128-bit and 256-bit keys.
- Runs the full decryption round schedule: initial AddRoundKey, Nr-1 main rounds, final round.
- The number of inverse S-box words processed per cycle is set by parameter, trading area for latency.
- Sits between the key memory (which supplies the round key for the index it drives) and the top-level core FSM (which issues next and waits for ready).

---
 rtl/aes_decipher_round_par.sv | 216 +++++++++++++++++++++
 tb/tb_aes_decipher_round_par.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_decipher_round_par.sv
// Iterative AES inverse cipher for 128/256-bit keys. NUM_SBOX inverse S-box lanes
// (32 bits each) trade area for SubBytes latency; the round key comes from external key memory.

module aes_decipher_round_par #(
    parameter int NUM_SBOX = 1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         next,
    input  logic         keylen,
    output logic [3:0]   round,
    input  logic [127:0] round_key,
    input  logic [127:0] block,
    output logic [127:0] new_block,
    output logic         ready
);
    localparam int S = 4 / NUM_SBOX;

    if (!(NUM_SBOX == 1 || NUM_SBOX == 2 || NUM_SBOX == 4)) begin : g_bad_num_sbox
        $fatal(1, "aes_decipher_round_par: NUM_SBOX must be 1, 2 or 4");
    end

    typedef enum logic [1:0] {
        IDLE,
        INIT,
        SBOX,
        MAIN
    } state_t;

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Multiply by a constant with bits {8,4,2,1}; covers 09, 0b, 0d and 0e.
    function automatic logic [7:0] gm_small(input logic [7:0] b, input logic [3:0] k);
        logic [7:0] m2, m4, m8;
        m2 = xt(b);
        m4 = xt(m2);
        m8 = xt(m4);
        return (k[0] ? b : 8'h00) ^ (k[1] ? m2 : 8'h00) ^ (k[2] ? m4 : 8'h00) ^ (k[3] ? m8 : 8'h00);
    endfunction

    function automatic logic [31:0] inv_mix_word(input logic [31:0] w);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = w;
        return {gm_small(a0, 4'he) ^ gm_small(a1, 4'hb) ^ gm_small(a2, 4'hd) ^ gm_small(a3, 4'h9),
                gm_small(a0, 4'h9) ^ gm_small(a1, 4'he) ^ gm_small(a2, 4'hb) ^ gm_small(a3, 4'hd),
                gm_small(a0, 4'hd) ^ gm_small(a1, 4'h9) ^ gm_small(a2, 4'he) ^ gm_small(a3, 4'hb),
                gm_small(a0, 4'hb) ^ gm_small(a1, 4'hd) ^ gm_small(a2, 4'h9) ^ gm_small(a3, 4'he)};
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int unsigned c = 0; c < 4; c++) begin
            r[127 - 32*c -: 32] = inv_mix_word(s[127 - 32*c -: 32]);
        end
        return r;
    endfunction

    // Row R rotates right by R: byte (R,C) takes the byte from column (C-R) mod 4.
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int unsigned c = 0; c < 4; c++) begin
            for (int unsigned row = 0; row < 4; row++) begin
                r[127 - 32*c - 8*row -: 8] = s[127 - 32*((c + 4 - row) % 4) - 8*row -: 8];
            end
        end
        return r;
    endfunction

    state_t           state_reg, state_new;
    logic [127:0]     block_reg, block_new;
    logic [3:0]       round_reg, round_new;
    logic [1:0]       sword_ctr_reg, sword_ctr_new;
    logic             keylen_reg, keylen_new;
    logic             ready_reg, ready_new;

    logic [0:3][31:0] cur_words;
    logic [0:3][31:0] sb_words;
    logic [127:0]     addk;
    logic [1:0]       lane_idx [NUM_SBOX];
    logic [31:0]      lane_word [NUM_SBOX];
    logic [31:0]      lane_sub [NUM_SBOX];

    assign cur_words = block_reg;
    assign round     = round_reg;
    assign new_block = block_reg;
    assign ready     = ready_reg;

    for (genvar g = 0; g < NUM_SBOX; g++) begin : g_lane
        assign lane_idx[g]  = 2'(sword_ctr_reg * NUM_SBOX + g);
        assign lane_word[g] = cur_words[lane_idx[g]];

        aes_inv_sbox u_inv_sbox (
            .sword    (lane_word[g]),
            .new_sword(lane_sub[g])
        );
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= IDLE;
            block_reg     <= '0;
            round_reg     <= '0;
            sword_ctr_reg <= '0;
            keylen_reg    <= 1'b0;
            ready_reg     <= 1'b1;
        end else begin
            state_reg     <= state_new;
            block_reg     <= block_new;
            round_reg     <= round_new;
            sword_ctr_reg <= sword_ctr_new;
            keylen_reg    <= keylen_new;
            ready_reg     <= ready_new;
        end
    end

    always_comb begin
        state_new     = state_reg;
        block_new     = block_reg;
        round_new     = round_reg;
        sword_ctr_new = sword_ctr_reg;
        keylen_new    = keylen_reg;
        ready_new     = ready_reg;
        sb_words      = block_reg;
        addk          = inv_shift_rows(block_reg) ^ round_key;

        for (int unsigned i = 0; i < NUM_SBOX; i++) begin
            sb_words[lane_idx[i]] = lane_sub[i];
        end

        unique case (state_reg)
            IDLE: begin
                if (next) begin
                    keylen_new = keylen;
                    round_new  = keylen ? 4'd14 : 4'd10;
                    ready_new  = 1'b0;
                    state_new  = INIT;
                end
            end
            INIT: begin
                block_new     = block ^ round_key;
                round_new     = (keylen_reg ? 4'd14 : 4'd10) - 4'd1;
                sword_ctr_new = '0;
                state_new     = SBOX;
            end
            SBOX: begin
                block_new = sb_words;
                if (sword_ctr_reg == 2'(S - 1)) begin
                    sword_ctr_new = '0;
                    state_new     = MAIN;
                end else begin
                    sword_ctr_new = sword_ctr_reg + 2'd1;
                end
            end
            MAIN: begin
                if (round_reg != 4'd0) begin
                    block_new = inv_mix_columns(addk);
                    round_new = round_reg - 4'd1;
                    state_new = SBOX;
                end else begin
                    block_new = addk;
                    ready_new = 1'b1;
                    state_new = IDLE;
                end
            end
            default: state_new = IDLE;
        endcase
    end

endmodule

// One 32-bit inverse S-box lane: GF(2^8) inverse of the inverse affine transform, per byte.
module aes_inv_sbox (
    input  logic [31:0] sword,
    output logic [31:0] new_sword
);
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa;
        p  = '0;
        aa = a;
        for (int unsigned i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // x^254 is the multiplicative inverse in GF(2^8) and maps 0 to 0.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] x2, x3, x12, x15, x240;
        x2   = gf_mul(x, x);
        x3   = gf_mul(x2, x);
        x12  = gf_mul(gf_mul(x3, x3), gf_mul(x3, x3));
        x15  = gf_mul(x12, x3);
        x240 = gf_mul(x15, x15);
        x240 = gf_mul(x240, x240);
        x240 = gf_mul(x240, x240);
        x240 = gf_mul(x240, x240);
        return gf_mul(gf_mul(x240, x12), x2);
    endfunction

    function automatic logic [7:0] inv_sbox_byte(input logic [7:0] b);
        return gf_inv({b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05);
    endfunction

    always_comb begin
        new_sword = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            new_sword[8*i +: 8] = inv_sbox_byte(sword[8*i +: 8]);
        end
    end

endmodule

// File: tb/tb_aes_decipher_round_par.sv
// Directed bench for aes_decipher_round_par: FIPS-197 / SP800-38A vectors on all three
// lane configurations, with the key memory modelled from a bench-side key expansion.

module tb_aes_decipher_round_par;
    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         next = 1'b0;
    logic         keylen = 1'b0;
    logic [127:0] block = '0;
    logic [3:0]   round1, round2, round4;
    logic [127:0] rk1, rk2, rk4, nb1, nb2, nb4;
    logic         ready1, ready2, ready4;
    logic [127:0] sched [16];
    logic [7:0]   sbox_tab [256];
    int           checks = 0;
    int           failures = 0;

    localparam logic [127:0] PT_FIPS = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C1   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT_C3   = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] CT_ECB  = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
    localparam logic [127:0] PT_ECB  = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [255:0] KEY_C1  = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [255:0] KEY_C3  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [255:0] KEY_ECB = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};

    always #5 clk = ~clk;

    assign rk1 = sched[round1];
    assign rk2 = sched[round2];
    assign rk4 = sched[round4];

    aes_decipher_round_par #(.NUM_SBOX(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .next(next), .keylen(keylen), .round(round1),
        .round_key(rk1), .block(block), .new_block(nb1), .ready(ready1));
    aes_decipher_round_par #(.NUM_SBOX(2)) dut2 (
        .clk(clk), .reset_n(reset_n), .next(next), .keylen(keylen), .round(round2),
        .round_key(rk2), .block(block), .new_block(nb2), .ready(ready2));
    aes_decipher_round_par #(.NUM_SBOX(4)) dut4 (
        .clk(clk), .reset_n(reset_n), .next(next), .keylen(keylen), .round(round4),
        .round_key(rk4), .block(block), .new_block(nb4), .ready(ready4));

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa;
        p  = '0;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Forward S-box by brute-force inverse search plus the forward affine map.
    task automatic build_sbox();
        logic [7:0] inv, x;
        for (int v = 0; v < 256; v++) begin
            x   = 8'(v);
            inv = 8'h00;
            if (v != 0) begin
                for (int y = 1; y < 256; y++) begin
                    if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
                end
            end
            sbox_tab[v] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                          {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
    endtask

    task automatic load_key(input logic [255:0] key, input logic is256);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc;
        int          nk, nr;
        nk = is256 ? 8 : 4;
        nr = is256 ? 14 : 10;
        rc = 8'h01;
        for (int i = 0; i < 4 * (nr + 1); i++) begin
            if (i < nk) begin
                w[i] = key[255 - 32*i -: 32];
            end else begin
                t = w[i-1];
                if (i % nk == 0) begin
                    t = {t[23:0], t[31:24]};
                    t = {sbox_tab[t[31:24]], sbox_tab[t[23:16]], sbox_tab[t[15:8]], sbox_tab[t[7:0]]};
                    t[31:24] = t[31:24] ^ rc;
                    rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
                end else if (nk == 8 && i % nk == 4) begin
                    t = {sbox_tab[t[31:24]], sbox_tab[t[23:16]], sbox_tab[t[15:8]], sbox_tab[t[7:0]]};
                end
                w[i] = w[i-nk] ^ t;
            end
        end
        for (int r = 0; r < 16; r++) begin
            if (r <= nr) sched[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
            else sched[r] = '0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic kl, input logic [127:0] blk);
        next   = 1'b1;
        keylen = kl;
        block  = blk;
        tick();
        next = 1'b0;
    endtask

    task automatic wait_ready1(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (ready1 !== 1'b1 && n < 300);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) tick();
        checks++; if (ready1 !== 1'b1) begin failures++; $display("FAIL reset_ready1: got %b want 1", ready1); end
        checks++; if (nb1 !== 128'h0) begin failures++; $display("FAIL reset_new_block: got %h want 0", nb1); end
        checks++; if (round1 !== 4'd0) begin failures++; $display("FAIL reset_round: got %0d want 0", round1); end
        checks++; if ({ready2, ready4} !== 2'b11) begin failures++; $display("FAIL reset_ready24: got %b want 11", {ready2, ready4}); end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_aes256_c3();
        int l1, l2, l4;
        l1 = 0; l2 = 0; l4 = 0;
        load_key(KEY_C3, 1'b1);
        start(1'b1, CT_C3);
        checks++; if ({ready1, ready2, ready4} !== 3'b000) begin failures++; $display("FAIL c3_busy: got %b want 000", {ready1, ready2, ready4}); end
        checks++; if (round1 !== 4'd14) begin failures++; $display("FAIL c3_round_init: got %0d want 14", round1); end
        for (int n = 1; n <= 300 && l1 == 0; n++) begin
            tick();
            if (ready1 === 1'b1 && l1 == 0) l1 = n;
            if (ready2 === 1'b1 && l2 == 0) l2 = n;
            if (ready4 === 1'b1 && l4 == 0) l4 = n;
        end
        checks++; if (l1 != 71) begin failures++; $display("FAIL c3_latency_n1: got %0d want 71", l1); end
        checks++; if (l2 != 43) begin failures++; $display("FAIL c3_latency_n2: got %0d want 43", l2); end
        checks++; if (l4 != 29) begin failures++; $display("FAIL c3_latency_n4: got %0d want 29", l4); end
        checks++; if (nb1 !== PT_FIPS) begin failures++; $display("FAIL c3_result_n1: got %h want %h", nb1, PT_FIPS); end
        checks++; if (nb2 !== PT_FIPS) begin failures++; $display("FAIL c3_result_n2: got %h want %h", nb2, PT_FIPS); end
        checks++; if (nb4 !== PT_FIPS) begin failures++; $display("FAIL c3_result_n4: got %h want %h", nb4, PT_FIPS); end
        tick();
    endtask

    task automatic test_aes128_c1();
        int n;
        load_key(KEY_C1, 1'b0);
        start(1'b0, CT_C1);
        wait_ready1(n);
        checks++; if (n != 51) begin failures++; $display("FAIL c1_latency: got %0d want 51", n); end
        checks++; if (nb1 !== PT_FIPS) begin failures++; $display("FAIL c1_result: got %h want %h", nb1, PT_FIPS); end
        checks++; if (round1 !== 4'd0) begin failures++; $display("FAIL c1_round_done: got %0d want 0", round1); end
        tick();
    endtask

    task automatic test_ecb_round_seq();
        logic [3:0] exp_round;
        load_key(KEY_ECB, 1'b0);
        start(1'b0, CT_ECB);
        checks++; if (round1 !== 4'd10) begin failures++; $display("FAIL ecb_round_k0: got %0d want 10", round1); end
        for (int k = 1; k <= 51; k++) begin
            tick();
            exp_round = (k <= 50) ? 4'(9 - (k - 1) / 5) : 4'd0;
            checks++; if (round1 !== exp_round) begin failures++; $display("FAIL ecb_round_k%0d: got %0d want %0d", k, round1, exp_round); end
        end
        checks++; if (ready1 !== 1'b1) begin failures++; $display("FAIL ecb_ready: got %b want 1", ready1); end
        checks++; if (nb1 !== PT_ECB) begin failures++; $display("FAIL ecb_result: got %h want %h", nb1, PT_ECB); end
        tick();
    endtask

    task automatic test_busy_robustness();
        int n;
        load_key(KEY_C1, 1'b0);
        start(1'b0, CT_C1);
        n = 0;
        do begin
            tick();
            n++;
            if (ready1 !== 1'b1) begin
                next   = (n == 50) ? 1'b1 : 1'($urandom);
                keylen = 1'($urandom);
                block  = {$urandom, $urandom, $urandom, $urandom};
            end
        end while (ready1 !== 1'b1 && n < 300);
        next = 1'b0;
        checks++; if (n != 51) begin failures++; $display("FAIL busy_latency: got %0d want 51", n); end
        checks++; if (nb1 !== PT_FIPS) begin failures++; $display("FAIL busy_result: got %h want %h", nb1, PT_FIPS); end
        tick();
        checks++; if (ready1 !== 1'b1) begin failures++; $display("FAIL busy_next_at_done_edge: ready got %b want 1", ready1); end
        checks++; if (nb1 !== PT_FIPS) begin failures++; $display("FAIL busy_result_hold: got %h want %h", nb1, PT_FIPS); end
    endtask

    task automatic test_async_reset();
        int n;
        load_key(KEY_C1, 1'b0);
        start(1'b0, CT_C1);
        repeat (19) tick();
        checks++; if (ready1 !== 1'b0) begin failures++; $display("FAIL arst_busy_before: got %b want 0", ready1); end
        #2;
        reset_n = 1'b0;
        #1;
        checks++; if (ready1 !== 1'b1) begin failures++; $display("FAIL arst_ready: got %b want 1", ready1); end
        checks++; if (nb1 !== 128'h0) begin failures++; $display("FAIL arst_new_block: got %h want 0", nb1); end
        checks++; if (round1 !== 4'd0) begin failures++; $display("FAIL arst_round: got %0d want 0", round1); end
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
        start(1'b0, CT_C1);
        wait_ready1(n);
        checks++; if (n != 51) begin failures++; $display("FAIL arst_rerun_latency: got %0d want 51", n); end
        checks++; if (nb1 !== PT_FIPS) begin failures++; $display("FAIL arst_rerun_result: got %h want %h", nb1, PT_FIPS); end
        tick();
    endtask

    task automatic test_back_to_back();
        int n1, n2;
        load_key(KEY_C1, 1'b0);
        next   = 1'b1;
        keylen = 1'b0;
        block  = CT_C1;
        tick();
        wait_ready1(n1);
        checks++; if (n1 != 51) begin failures++; $display("FAIL b2b_first_latency: got %0d want 51", n1); end
        checks++; if (nb1 !== PT_FIPS) begin failures++; $display("FAIL b2b_first_result: got %h want %h", nb1, PT_FIPS); end
        tick();
        checks++; if (ready1 !== 1'b0) begin failures++; $display("FAIL b2b_restart: ready got %b want 0", ready1); end
        wait_ready1(n2);
        next = 1'b0;
        checks++; if (n2 + 1 != 52) begin failures++; $display("FAIL b2b_period: got %0d want 52", n2 + 1); end
        checks++; if (nb1 !== PT_FIPS) begin failures++; $display("FAIL b2b_second_result: got %h want %h", nb1, PT_FIPS); end
        tick();
        checks++; if (ready1 !== 1'b1) begin failures++; $display("FAIL b2b_idle_after: got %b want 1", ready1); end
    endtask

    initial begin
        build_sbox();
        test_reset();
        test_aes256_c3();
        test_aes128_c1();
        test_ecb_round_seq();
        test_busy_robustness();
        test_async_reset();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
